// File: rtl/narrow_pkg.sv
// Shared widths, byte saturation limits and the buffered {sat, byte} record
// for the 20-to-8-bit narrowing unit.
package narrow_pkg;
    localparam int W_WIDE      = 20;
    localparam int W_NARROW    = 8;
    localparam logic [W_NARROW-1:0] BYTE_MAX = 8'h7F;
    localparam logic [W_NARROW-1:0] BYTE_MIN = 8'h80;
    localparam int SAT_CNT_MAX = 255;

    typedef struct packed {
        logic                sat;
        logic [W_NARROW-1:0] data;
    } narrow_t;
endpackage

// File: rtl/narrow_sat_if.sv
// Producer/consumer handshake bundle around the narrowing unit.
interface narrow_sat_if;
    import narrow_pkg::*;

    logic signed [W_WIDE-1:0]   in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [W_NARROW-1:0] out_data;
    logic                       out_sat;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/narrow_fifo2.sv
// Two-entry FIFO with push/pop/occupancy; only the control state is reset,
// the storage is qualified by the occupancy count downstream.
module narrow_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/narrow_sat.sv
// Narrows signed 20-bit words to saturated signed bytes at accept time,
// buffers two results and counts saturated accepts (sticky at the maximum).
module narrow_sat
    import narrow_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    narrow_sat_if.slave  bus,
    input  logic         cnt_clr,
    output logic [7:0]   sat_count
);
    // A word fits when every bit from the byte sign bit upward agrees.
    function automatic narrow_t narrow_word(input logic signed [W_WIDE-1:0] w);
        narrow_t r;
        if ((&w[W_WIDE-1:W_NARROW-1]) || ~(|w[W_WIDE-1:W_NARROW-1])) begin
            r.sat  = 1'b0;
            r.data = w[W_NARROW-1:0];
        end else begin
            r.sat  = 1'b1;
            r.data = w[W_WIDE-1] ? BYTE_MIN : BYTE_MAX;
        end
        return r;
    endfunction

    logic [1:0] count;
    narrow_t    head, nw;
    logic       push, pop, in_ready, out_valid;
    logic [7:0] sat_cnt_q, sat_cnt_d;

    assign nw        = narrow_word(bus.in_data);
    assign in_ready  = (count != 2'd2) & ~rst;
    assign out_valid = (count != 2'd0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    narrow_fifo2 #(.WIDTH($bits(narrow_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (nw),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head.data : '0;
    assign bus.out_sat   = out_valid & head.sat;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (cnt_clr)
            sat_cnt_d = 8'd0;
        else if (push && nw.sat && (sat_cnt_q != 8'(SAT_CNT_MAX)))
            sat_cnt_d = sat_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= 8'd0;
        else     sat_cnt_q <= sat_cnt_d;
    end

    assign sat_count = sat_cnt_q;
endmodule

// File: tb/tb_narrow_sat.sv
// Self-checking bench for narrow_sat: vector table, directed corner
// sequences and a random stream against a queue-based reference model.
module tb_narrow_sat;
    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_clr;
    logic [7:0] sat_count;
    int         checks = 0;
    int         failures = 0;

    narrow_sat_if bus ();

    narrow_sat dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] word;
        logic [7:0]  exp_byte;
        logic        exp_sat;
    } vec_t;

    logic [8:0] mq[$];
    int         m_sat = 0;

    function automatic logic [8:0] ref_narrow(input logic [19:0] w);
        int v;
        v = int'($signed(w));
        if (v > 127)  return {1'b1, 8'h7F};
        if (v < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(v)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, compare against the model, advance one cycle.
    task automatic step(input logic v, input logic [19:0] d, input logic ordy, input logic clr);
        logic [8:0] hd, nw;
        bit m_ir, m_ov, acc, pp;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cnt_clr       = clr;
        #1;
        m_ir = (mq.size() < 2);
        m_ov = (mq.size() > 0);
        hd   = m_ov ? mq[0] : 9'd0;
        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ir});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        check("out_data",  {24'd0, $unsigned(bus.out_data)}, {24'd0, hd[7:0]});
        check("out_sat",   {31'd0, bus.out_sat},   {31'd0, hd[8]});
        check("sat_count", {24'd0, sat_count},     m_sat);
        acc = v & m_ir;
        pp  = ordy & m_ov;
        nw  = ref_narrow(d);
        if (pp)  void'(mq.pop_front());
        if (acc) mq.push_back(nw);
        if (clr) m_sat = 0;
        else if (acc && nw[8] && m_sat < 255) m_sat++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[10];
        int   tsat;
        rst = 1'b1; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        vt[0] = '{20'h0007F, 8'h7F, 1'b0};
        vt[1] = '{20'hFFF80, 8'h80, 1'b0};
        vt[2] = '{20'h00080, 8'h7F, 1'b1};
        vt[3] = '{20'h80000, 8'h80, 1'b1};
        vt[4] = '{20'h00000, 8'h00, 1'b0};
        vt[5] = '{20'hFFFFF, 8'hFF, 1'b0};
        vt[6] = '{20'h7FFFF, 8'h7F, 1'b1};
        vt[7] = '{20'hFFF7F, 8'h80, 1'b1};
        vt[8] = '{20'h00040, 8'h40, 1'b0};
        vt[9] = '{20'hFFF81, 8'h81, 1'b0};

        @(negedge clk); @(negedge clk);
        check("rst_in_ready",  {31'd0, bus.in_ready},  0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_data",  {24'd0, $unsigned(bus.out_data)}, 0);
        check("rst_sat_count", {24'd0, sat_count}, 0);
        rst = 1'b0;

        tsat = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vt[i].word, 1'b1, 1'b0);
            check("vec_valid", {31'd0, bus.out_valid}, 1);
            check("vec_byte",  {24'd0, $unsigned(bus.out_data)}, {24'd0, vt[i].exp_byte});
            check("vec_sat",   {31'd0, bus.out_sat}, {31'd0, vt[i].exp_sat});
            if (vt[i].exp_sat) tsat++;
            if (i == 1) check("vec_cnt_after_fit", {24'd0, sat_count}, 0);
            if (i == 3) check("vec_cnt_after_sat", {24'd0, sat_count}, 2);
        end
        check("vec_cnt_total", {24'd0, sat_count}, tsat);
        step(1'b0, 20'h0, 1'b1, 1'b0);

        // Backpressure: two absorbed, third held off until after the first pop.
        step(1'b1, 20'h00011, 1'b0, 1'b0);
        step(1'b1, 20'h00022, 1'b0, 1'b0);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 0);
        step(1'b1, 20'h00033, 1'b0, 1'b0);
        check("bp_head_first", {24'd0, $unsigned(bus.out_data)}, 32'h11);
        step(1'b1, 20'h00033, 1'b1, 1'b0);
        check("bp_in_ready_back", {31'd0, bus.in_ready}, 1);
        check("bp_head_second", {24'd0, $unsigned(bus.out_data)}, 32'h22);
        step(1'b1, 20'h00033, 1'b1, 1'b0);
        check("bp_head_third", {24'd0, $unsigned(bus.out_data)}, 32'h33);
        step(1'b0, 20'h0, 1'b1, 1'b0);
        check("bp_drained", {31'd0, bus.out_valid}, 0);

        // Steady push+pop at occupancy 1.
        step(1'b1, 20'h00005, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 20'($urandom_range(0, 255)), 1'b1, 1'b0);
            check("pp_count1", {30'd0, bus.in_ready, bus.out_valid}, 32'h3);
        end
        step(1'b0, 20'h0, 1'b1, 1'b0);

        // Sticky saturation counter and clear priority.
        step(1'b0, 20'h0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 20'h40000, 1'b1, 1'b0);
        check("cnt_sticky", {24'd0, sat_count}, 255);
        step(1'b1, 20'hC0000, 1'b1, 1'b1);
        check("cnt_clr_prio", {24'd0, sat_count}, 0);
        step(1'b0, 20'h0, 1'b1, 1'b0);

        // Random traffic with inputs changing while in_valid is low.
        for (int i = 0; i < 400; i++) begin
            logic [19:0] w;
            w = ($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'($signed($urandom_range(0, 511)) - 256);
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        step(1'b0, 20'h0, 1'b1, 1'b0);
        step(1'b0, 20'h0, 1'b1, 1'b0);

        // Reset while full and with a nonzero counter.
        step(1'b1, 20'h20000, 1'b0, 1'b0);
        step(1'b1, 20'h00012, 1'b0, 1'b0);
        check("mid_full", {31'd0, bus.in_ready}, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("mid_rst_out_data",  {24'd0, $unsigned(bus.out_data)}, 0);
        check("mid_rst_out_sat",   {31'd0, bus.out_sat}, 0);
        check("mid_rst_sat_count", {24'd0, sat_count}, 0);
        check("mid_rst_in_ready",  {31'd0, bus.in_ready}, 0);
        mq.delete();
        m_sat = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 20'hFFFC3, 1'b1, 1'b0);
        check("post_rst_byte", {24'd0, $unsigned(bus.out_data)}, 32'hC3);
        step(1'b0, 20'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
